// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 Local Binary Pattern engine: raster-order reads, two line buffers
// plus a 3x3 window, one LBP code written per accepted (or flushed) pixel.
module lbp_stream_engine #(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 14,
  parameter int BORDER_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);
  // state   | meaning
  // S_IDLE  | waiting for gray_ready
  // S_RUN   | one read per cycle while gray_ready is high
  // S_FLUSH | phantom pixels push out the last row and last column
  // S_DONE  | finish held until reset
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + IMG_W + 2);
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic [XW-1:0]     col_q, col_d;
  logic [XW-1:0]     ocol_q;
  logic [YW-1:0]     orow_q;
  logic [ADDR_W-1:0] oidx_q;
  logic              pend_q;
  logic              lbp_valid_q;
  logic [ADDR_W-1:0] lbp_addr_q;
  logic [7:0]        lbp_data_q;
  logic              finish_q;

  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [2:0][2:0][DATA_W-1:0] win_q;

  logic              accept;
  logic [DATA_W-1:0] pix_in;
  logic              last_wr;
  logic              top_e, bot_e, left_e, right_e;
  logic [2:0][2:0][DATA_W-1:0] rsel, nb;
  logic [DATA_W-1:0] gc;
  logic [7:0]        code;

  // Output k leaves the window on the accept of index k+IMG_W+1; flush supplies
  // the final IMG_W+1 accepts with dummy pixels that the edge muxes discard.
  assign accept  = (state_q == S_RUN && gray_ready) ||
                   (state_q == S_FLUSH && acc_q <= CW'(NPIX + IMG_W));
  assign pix_in  = (state_q == S_RUN) ? gray_data : '0;
  assign last_wr = lbp_valid_q && (lbp_addr_q == ADDR_W'(NPIX - 1));

  assign gray_req  = (state_q == S_RUN) && gray_ready;
  assign gray_addr = (state_q == S_RUN) ? ADDR_W'(acc_q) : '0;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    col_d   = col_q;
    if (accept) begin
      acc_d = acc_q + 1'b1;
      col_d = (col_q == XW'(IMG_W - 1)) ? '0 : col_q + 1'b1;
    end
    case (state_q)
      S_IDLE:  if (gray_ready) state_d = S_RUN;
      S_RUN:   if (accept && acc_q == CW'(NPIX - 1)) state_d = S_FLUSH;
      S_FLUSH: if (last_wr) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  // Clamp out-of-image neighbours onto the centre row/column.
  assign top_e   = (orow_q == '0);
  assign bot_e   = (orow_q == YW'(IMG_H - 1));
  assign left_e  = (ocol_q == '0);
  assign right_e = (ocol_q == XW'(IMG_W - 1));
  assign gc      = win_q[1][1];

  always_comb begin
    rsel = '0;
    nb   = '0;
    for (int j = 0; j < 3; j++) begin
      rsel[0][j] = top_e ? win_q[1][j] : win_q[0][j];
      rsel[1][j] = win_q[1][j];
      rsel[2][j] = bot_e ? win_q[1][j] : win_q[2][j];
    end
    for (int i = 0; i < 3; i++) begin
      nb[i][0] = left_e  ? rsel[i][1] : rsel[i][0];
      nb[i][1] = rsel[i][1];
      nb[i][2] = right_e ? rsel[i][1] : rsel[i][2];
    end
    code = {nb[2][2] >= gc, nb[2][1] >= gc, nb[2][0] >= gc, nb[1][2] >= gc,
            nb[1][0] >= gc, nb[0][2] >= gc, nb[0][1] >= gc, nb[0][0] >= gc};
    if (BORDER_MODE == 0 && (top_e || bot_e || left_e || right_e)) code = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      col_q       <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      oidx_q      <= '0;
      pend_q      <= 1'b0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      col_q    <= col_d;
      pend_q   <= accept && (acc_q >= CW'(IMG_W + 1));
      finish_q <= finish_q || last_wr;
      if (pend_q) begin
        lbp_valid_q <= 1'b1;
        lbp_addr_q  <= oidx_q;
        lbp_data_q  <= code;
        oidx_q      <= oidx_q + 1'b1;
        if (right_e) begin
          ocol_q <= '0;
          orow_q <= orow_q + 1'b1;
        end else begin
          ocol_q <= ocol_q + 1'b1;
        end
      end else begin
        lbp_valid_q <= 1'b0;
        lbp_addr_q  <= '0;
        lbp_data_q  <= '0;
      end
    end
  end

  // Line buffers and window carry pure data; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_in;
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= lb1_q[col_q];
      win_q[1][2] <= lb0_q[col_q];
      win_q[2][2] <= pix_in;
    end
  end
endmodule
